com_bus_arbiter_n: RTL

- Parametrised common-bus arbiter and coherence-response collector for the multi-core cache cluster.
- Grants the shared Address_Com/Data_Bus_Com bus to one of NUM_PROC processor-side requesters or NUM_CORES snoop-side requesters.
- Snoop requesters have priority; each class is arbitrated round-robin.
- Tracks invalidation acknowledgements only from caches that actually held the line, so the invalidating owner is not waiting on non-sharers.

---
 rtl/com_bus_arbiter_n.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/com_bus_arbiter_n.sv
// Common-bus arbiter: snoop-first round-robin grant plus invalidation-ack collection.
// Optional hold watchdog is enabled by defining COM_BUS_TIMEOUT_EN.
module com_bus_arbiter_n #(
   parameter int NUM_CORES = 4,
   parameter int NUM_PROC  = 8,
   parameter int MAX_HOLD  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
   output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
   input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
   output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
   input  logic                 Invalidate,
   input  logic [NUM_CORES-1:0] Shared_local,
   input  logic [NUM_CORES-1:0] Invalidation_done,
   output logic                 Shared,
   output logic                 All_Invalidation_done,
   output logic                 Bus_busy,
   output logic                 Timeout_err
);

   localparam int PW = (NUM_PROC  > 1) ? $clog2(NUM_PROC)  : 1;
   localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {IDLE, GNT_PROC, GNT_SNOOP, INV_WAIT} state_t;

   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD must be at least 1");
   end

   state_t               state, state_nxt;
   logic [PW-1:0]        proc_ptr, proc_ptr_nxt;
   logic [SW-1:0]        snoop_ptr, snoop_ptr_nxt;
   logic [PW-1:0]        owner_proc, owner_proc_nxt;
   logic [SW-1:0]        owner_snoop, owner_snoop_nxt;
   logic [NUM_CORES-1:0] sharer_mask, sharer_mask_nxt;
   logic [NUM_PROC-1:0]  gnt_proc_nxt;
   logic [NUM_CORES-1:0] gnt_snoop_nxt;
   logic                 inv_done_nxt;

   logic                 proc_found, snoop_found;
   logic [PW-1:0]        proc_win;
   logic [SW-1:0]        snoop_win;
   logic [NUM_CORES-1:0] owner_core;
   logic                 proc_owner_req, snoop_owner_req;
   logic [NUM_CORES-1:0] mask_after_ack;

   function automatic logic [PW-1:0] proc_idx(input logic [PW-1:0] base, input int off);
      return PW'((int'(base) + off) % NUM_PROC);
   endfunction

   function automatic logic [SW-1:0] snoop_idx(input logic [SW-1:0] base, input int off);
      return SW'((int'(base) + off) % NUM_CORES);
   endfunction

   assign Shared = |Shared_local;

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      proc_found = 1'b0;
      proc_win   = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         if (!proc_found && Com_Bus_Req_proc[proc_idx(proc_ptr, i)]) begin
            proc_found = 1'b1;
            proc_win   = proc_idx(proc_ptr, i);
         end
      end
   end

   always_comb begin
      snoop_found = 1'b0;
      snoop_win   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!snoop_found && Com_Bus_Req_snoop[snoop_idx(snoop_ptr, i)]) begin
            snoop_found = 1'b1;
            snoop_win   = snoop_idx(snoop_ptr, i);
         end
      end
   end

   // Instruction-cache owners (index >= NUM_CORES) map to no core bit.
   always_comb begin
      owner_core = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         owner_core[c] = (int'(owner_proc) == c);
      end
   end

   assign proc_owner_req  = Com_Bus_Req_proc[owner_proc];
   assign snoop_owner_req = Com_Bus_Req_snoop[owner_snoop];
   assign mask_after_ack  = sharer_mask & ~Invalidation_done;

`ifdef COM_BUS_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt, hold_cnt_nxt;
   logic          timeout_q, timeout_nxt;
`endif

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt       = state;
      proc_ptr_nxt    = proc_ptr;
      snoop_ptr_nxt   = snoop_ptr;
      owner_proc_nxt  = owner_proc;
      owner_snoop_nxt = owner_snoop;
      sharer_mask_nxt = sharer_mask;
      gnt_proc_nxt    = Com_Bus_Gnt_proc;
      gnt_snoop_nxt   = Com_Bus_Gnt_snoop;
      inv_done_nxt    = 1'b0;

      case (state)
         IDLE: begin
            sharer_mask_nxt = '0;
            if (snoop_found) begin
               gnt_snoop_nxt            = '0;
               gnt_snoop_nxt[snoop_win] = 1'b1;
               owner_snoop_nxt          = snoop_win;
               snoop_ptr_nxt            = snoop_idx(snoop_win, 1);
               state_nxt                = GNT_SNOOP;
            end else if (proc_found) begin
               gnt_proc_nxt           = '0;
               gnt_proc_nxt[proc_win] = 1'b1;
               owner_proc_nxt         = proc_win;
               proc_ptr_nxt           = proc_idx(proc_win, 1);
               state_nxt              = GNT_PROC;
            end
         end

         GNT_SNOOP: begin
            if (!snoop_owner_req) begin
               gnt_snoop_nxt = '0;
               state_nxt     = IDLE;
            end
         end

         GNT_PROC: begin
            if (!proc_owner_req) begin
               gnt_proc_nxt = '0;
               state_nxt    = IDLE;
            end else if (Invalidate) begin
               sharer_mask_nxt = Shared_local & ~owner_core;
               state_nxt       = INV_WAIT;
            end
         end

         INV_WAIT: begin
            if (!proc_owner_req) begin
               gnt_proc_nxt    = '0;
               sharer_mask_nxt = '0;
               state_nxt       = IDLE;
            end else begin
               sharer_mask_nxt = mask_after_ack;
               if (mask_after_ack == '0) begin
                  inv_done_nxt = 1'b1;
                  state_nxt    = GNT_PROC;
               end
            end
         end

         default: begin
            gnt_proc_nxt    = '0;
            gnt_snoop_nxt   = '0;
            sharer_mask_nxt = '0;
            state_nxt       = IDLE;
         end
      endcase

`ifdef COM_BUS_TIMEOUT_EN
      timeout_nxt  = timeout_q;
      hold_cnt_nxt = (state == IDLE) ? '0 : hold_cnt + 1'b1;
      // The watchdog overrides everything else, including a completing invalidation.
      if (state != IDLE && hold_cnt == HW'(MAX_HOLD - 1)) begin
         gnt_proc_nxt    = '0;
         gnt_snoop_nxt   = '0;
         sharer_mask_nxt = '0;
         inv_done_nxt    = 1'b0;
         state_nxt       = IDLE;
         hold_cnt_nxt    = '0;
         timeout_nxt     = 1'b1;
      end
`endif
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                 <= IDLE;
         proc_ptr              <= '0;
         snoop_ptr             <= '0;
         owner_proc            <= '0;
         owner_snoop           <= '0;
         sharer_mask           <= '0;
         Com_Bus_Gnt_proc      <= '0;
         Com_Bus_Gnt_snoop     <= '0;
         All_Invalidation_done <= 1'b0;
         Bus_busy              <= 1'b0;
      end else begin
         state                 <= state_nxt;
         proc_ptr              <= proc_ptr_nxt;
         snoop_ptr             <= snoop_ptr_nxt;
         owner_proc            <= owner_proc_nxt;
         owner_snoop           <= owner_snoop_nxt;
         sharer_mask           <= sharer_mask_nxt;
         Com_Bus_Gnt_proc      <= gnt_proc_nxt;
         Com_Bus_Gnt_snoop     <= gnt_snoop_nxt;
         All_Invalidation_done <= inv_done_nxt;
         Bus_busy              <= (|gnt_proc_nxt) | (|gnt_snoop_nxt);
      end
   end

`ifdef COM_BUS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_cnt  <= hold_cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   assign Timeout_err = timeout_q;
`else
   assign Timeout_err = 1'b0;
`endif

   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop}));

endmodule
